// File: rtl/beatmap_pattern_gen.sv
// Beatmap note-position generator: arithmetic sequence per beat tick with wrap/bounce/one-shot modes.
// Optional LOOP_CNT_EN adds a saturating loop counter output (loop_cnt).
module beatmap_pattern_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned START  = 180,
    parameter int unsigned STOP   = 196,
    parameter int unsigned STEP   = 4,
    parameter int unsigned MODE   = 0,
    parameter int unsigned LOOP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
`ifdef LOOP_CNT_EN
    output logic [LOOP_W-1:0] loop_cnt,
`endif
    output logic              overrun
);

    localparam int unsigned SUM_W = DATA_W + 1;
    localparam logic [SUM_W-1:0]  START_S = SUM_W'(START);
    localparam logic [SUM_W-1:0]  STOP_S  = SUM_W'(STOP);
    localparam logic [SUM_W-1:0]  STEP_S  = SUM_W'(STEP);
    localparam logic [DATA_W-1:0] START_D = DATA_W'(START);
    localparam bit BOUNCE  = (MODE == 1);
    localparam bit ONESHOT = (MODE == 2);

    if (START > STOP) begin : g_chk_range
        $fatal(1, "beatmap_pattern_gen: START must not exceed STOP");
    end
    if (STEP < 1) begin : g_chk_step
        $fatal(1, "beatmap_pattern_gen: STEP must be at least 1");
    end
    if (64'(STOP) >= (64'(1) << DATA_W)) begin : g_chk_width
        $fatal(1, "beatmap_pattern_gen: STOP does not fit in DATA_W bits");
    end
    if (MODE > 2) begin : g_chk_mode
        $fatal(1, "beatmap_pattern_gen: MODE must be 0, 1 or 2");
    end
    if (BOUNCE && ((STOP - START) < STEP)) begin : g_chk_bounce
        $fatal(1, "beatmap_pattern_gen: bounce needs STOP - START >= STEP");
    end
    if (LOOP_W < 1) begin : g_chk_loop
        $fatal(1, "beatmap_pattern_gen: LOOP_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   next_pos, pos_nxt, data_nxt;
    logic                dir_down, dir_nxt;
    logic                last, last_nxt;
    logic                valid_nxt, done_nxt, overrun_nxt;

    logic [SUM_W-1:0]    cur_s, sum_s, diff_s;
    logic                over, low;
    logic [DATA_W-1:0]   adv_pos;
    logic                adv_dir, adv_last;

`ifdef LOOP_CNT_EN
    logic [LOOP_W-1:0]   loop_nxt;
    logic                seen, seen_nxt;
`endif

    // Successor of the sample being loaded, computed one bit wider to catch overflow past STOP
    always_comb begin
        cur_s    = {1'b0, next_pos};
        sum_s    = cur_s + STEP_S;
        diff_s   = cur_s - STEP_S;
        over     = (sum_s > STOP_S);
        low      = (cur_s < (START_S + STEP_S));
        adv_pos  = DATA_W'(sum_s);
        adv_dir  = dir_down;
        adv_last = 1'b0;
        if (BOUNCE) begin
            if (!dir_down) begin
                if (over) begin
                    adv_dir = 1'b1;
                    adv_pos = DATA_W'(diff_s);
                end
            end else if (low) begin
                adv_dir = 1'b0;
            end else begin
                adv_pos = DATA_W'(diff_s);
            end
        end else if (ONESHOT) begin
            adv_last = over;
        end else if (over) begin
            adv_pos = START_D;
        end
    end

    // Next-state and registered-output logic; stop beats start, start beats tick
    always_comb begin
        state_nxt   = state;
        data_nxt    = data;
        valid_nxt   = out_valid;
        done_nxt    = done;
        overrun_nxt = overrun;
        dir_nxt     = dir_down;
        pos_nxt     = next_pos;
        last_nxt    = last;
`ifdef LOOP_CNT_EN
        loop_nxt    = loop_cnt;
        seen_nxt    = seen;
`endif
        if (stop) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
        end else if (start) begin
            state_nxt   = S_RUN;
            valid_nxt   = 1'b0;
            done_nxt    = 1'b0;
            overrun_nxt = 1'b0;
            dir_nxt     = 1'b0;
            pos_nxt     = START_D;
            last_nxt    = 1'b0;
`ifdef LOOP_CNT_EN
            loop_nxt    = '0;
            seen_nxt    = 1'b0;
`endif
        end else if (state == S_RUN) begin
            if (out_valid && out_ready) begin
                valid_nxt = 1'b0;
                if (last) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
`ifdef LOOP_CNT_EN
                if (data == START_D) begin
                    if (seen && !(&loop_cnt)) begin
                        loop_nxt = loop_cnt + LOOP_W'(1);
                    end
                    seen_nxt = 1'b1;
                end
`endif
            end
            // Once the final one-shot sample is loaded, further ticks are simply ignored
            if (tick && !last) begin
                if (out_valid && !out_ready) begin
                    overrun_nxt = 1'b1;
                end else begin
                    data_nxt  = next_pos;
                    valid_nxt = 1'b1;
                    pos_nxt   = adv_pos;
                    dir_nxt   = adv_dir;
                    last_nxt  = adv_last;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            data      <= START_D;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            dir_down  <= 1'b0;
            next_pos  <= START_D;
            last      <= 1'b0;
`ifdef LOOP_CNT_EN
            loop_cnt  <= '0;
            seen      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            data      <= data_nxt;
            out_valid <= valid_nxt;
            busy      <= (state_nxt == S_RUN);
            done      <= done_nxt;
            overrun   <= overrun_nxt;
            dir_down  <= dir_nxt;
            next_pos  <= pos_nxt;
            last      <= last_nxt;
`ifdef LOOP_CNT_EN
            loop_cnt  <= loop_nxt;
            seen      <= seen_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_beatmap_pattern_gen.sv
// Directed bench: four generator variants (wrap, wrap STEP=5, bounce, one-shot) share one stimulus stream.
module tb_beatmap_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, tick, out_ready;
    logic [3:0] vld, bsy, dn, ovr;
    logic [7:0] dat [4];
`ifdef LOOP_CNT_EN
    logic [7:0] lc [4];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beatmap_pattern_gen #(.STEP(4), .MODE(0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick), .out_ready(out_ready),
        .out_valid(vld[0]), .data(dat[0]), .busy(bsy[0]), .done(dn[0]),
`ifdef LOOP_CNT_EN
        .loop_cnt(lc[0]),
`endif
        .overrun(ovr[0]));

    beatmap_pattern_gen #(.STEP(5), .MODE(0)) u_wrap5 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick), .out_ready(out_ready),
        .out_valid(vld[1]), .data(dat[1]), .busy(bsy[1]), .done(dn[1]),
`ifdef LOOP_CNT_EN
        .loop_cnt(lc[1]),
`endif
        .overrun(ovr[1]));

    beatmap_pattern_gen #(.STEP(4), .MODE(1)) u_bounce (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick), .out_ready(out_ready),
        .out_valid(vld[2]), .data(dat[2]), .busy(bsy[2]), .done(dn[2]),
`ifdef LOOP_CNT_EN
        .loop_cnt(lc[2]),
`endif
        .overrun(ovr[2]));

    beatmap_pattern_gen #(.STEP(4), .MODE(2)) u_oneshot (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .tick(tick), .out_ready(out_ready),
        .out_valid(vld[3]), .data(dat[3]), .busy(bsy[3]), .done(dn[3]),
`ifdef LOOP_CNT_EN
        .loop_cnt(lc[3]),
`endif
        .overrun(ovr[3]));

    typedef struct packed {
        logic            st;
        logic            tk;
        logic [3:0]      v;
        logic [3:0][7:0] d;
        logic            osd;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic st, input logic tk, input logic [3:0] v,
                                input int d0, input int d1, input int d2, input int d3,
                                input logic osd);
        vec_t r;
        r.st  = st;
        r.tk  = tk;
        r.v   = v;
        r.d   = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
        r.osd = osd;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, drop the pulses
    task automatic cyc(input logic st, input logic sp, input logic tk, input logic rd);
        start     = st;
        stop      = sp;
        tick      = tk;
        out_ready = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; tick = 1'b0; out_ready = 1'b1;

        //          st tk  valid   wrap wrap5 bnc  one  os_done
        tbl[0]  = mk(1, 0, 4'b0000, 180, 180, 180, 180, 0);
        tbl[1]  = mk(0, 1, 4'b1111, 180, 180, 180, 180, 0);
        tbl[2]  = mk(0, 0, 4'b0000, 180, 180, 180, 180, 0);
        tbl[3]  = mk(0, 1, 4'b1111, 184, 185, 184, 184, 0);
        tbl[4]  = mk(0, 0, 4'b0000, 184, 185, 184, 184, 0);
        tbl[5]  = mk(0, 1, 4'b1111, 188, 190, 188, 188, 0);
        tbl[6]  = mk(0, 0, 4'b0000, 188, 190, 188, 188, 0);
        tbl[7]  = mk(0, 1, 4'b1111, 192, 195, 192, 192, 0);
        tbl[8]  = mk(0, 0, 4'b0000, 192, 195, 192, 192, 0);
        tbl[9]  = mk(0, 1, 4'b1111, 196, 180, 196, 196, 0);
        tbl[10] = mk(0, 0, 4'b0000, 196, 180, 196, 196, 1);
        tbl[11] = mk(0, 1, 4'b0111, 180, 185, 192, 196, 1);
        tbl[12] = mk(0, 0, 4'b0000, 180, 185, 192, 196, 1);
        tbl[13] = mk(0, 1, 4'b0111, 184, 190, 188, 196, 1);
        tbl[14] = mk(0, 0, 4'b0000, 184, 190, 188, 196, 1);
        tbl[15] = mk(0, 1, 4'b0111, 188, 195, 184, 196, 1);
        tbl[16] = mk(0, 0, 4'b0000, 188, 195, 184, 196, 1);
        tbl[17] = mk(0, 1, 4'b0111, 192, 180, 180, 196, 1);
        tbl[18] = mk(0, 0, 4'b0000, 192, 180, 180, 196, 1);
        tbl[19] = mk(0, 1, 4'b0111, 196, 185, 184, 196, 1);

        // Reset values, checked while reset is still asserted
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset valid u%0d", i), int'(vld[i]), 0);
            chk($sformatf("reset data u%0d", i), int'(dat[i]), 180);
            chk($sformatf("reset busy u%0d", i), int'(bsy[i]), 0);
            chk($sformatf("reset done u%0d", i), int'(dn[i]), 0);
            chk($sformatf("reset overrun u%0d", i), int'(ovr[i]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Main sequences with out_ready held high, one tick every other cycle
        for (int r = 0; r < 20; r++) begin
            cyc(tbl[r].st, 1'b0, tbl[r].tk, 1'b1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("row%0d valid u%0d", r, i), int'(vld[i]), int'(tbl[r].v[i]));
                chk($sformatf("row%0d data u%0d", r, i), int'(dat[i]), int'(tbl[r].d[i]));
                chk($sformatf("row%0d busy u%0d", r, i), int'(bsy[i]), (i == 3) ? int'(!tbl[r].osd) : 1);
                chk($sformatf("row%0d done u%0d", r, i), int'(dn[i]), (i == 3) ? int'(tbl[r].osd) : 0);
                chk($sformatf("row%0d overrun u%0d", r, i), int'(ovr[i]), 0);
            end
        end

        // Restart from DONE with a simultaneous tick: start wins, tick ignored
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("restart oneshot busy", int'(bsy[3]), 1);
        chk("restart oneshot done", int'(dn[3]), 0);
        chk("restart tick ignored", int'(vld[0]), 0);

        // Stop discards a pending sample
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre-stop valid", int'(vld[0]), 1);
        chk("pre-stop data", int'(dat[0]), 180);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop valid", int'(vld[0]), 0);
        chk("stop busy", int'(bsy[0]), 0);
        chk("stop data held", int'(dat[0]), 180);
        chk("stop oneshot done", int'(dn[3]), 0);

        // Tick in IDLE is ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("idle tick valid", int'(vld[0]), 0);

        // Backpressure: second tick is dropped and flagged, then tick with acceptance
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp first valid", int'(vld[0]), 1);
        chk("bp first overrun", int'(ovr[0]), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp held data", int'(dat[0]), 180);
        chk("bp held valid", int'(vld[0]), 1);
        chk("bp overrun", int'(ovr[0]), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp accept+tick data", int'(dat[0]), 184);
        chk("bp accept+tick valid", int'(vld[0]), 1);
        chk("bp overrun sticky", int'(ovr[0]), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp drain valid", int'(vld[0]), 0);

        // Asynchronous reset in the middle of RUN at data 188
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("pre-reset data", int'(dat[0]), 188);
        chk("pre-reset valid", int'(vld[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset valid", int'(vld[0]), 0);
        chk("async reset data", int'(dat[0]), 180);
        chk("async reset overrun", int'(ovr[0]), 0);
        chk("async reset busy", int'(bsy[0]), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("post-reset data", int'(dat[0]), 180);
        chk("post-reset valid", int'(vld[0]), 1);
        chk("post-reset overrun", int'(ovr[0]), 0);
        chk("post-reset done", int'(dn[3]), 0);

        // Back-to-back ticks with acceptance keep valid high
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2b data", int'(dat[0]), 184);
        chk("b2b valid", int'(vld[0]), 1);

        // start and stop together: stop wins, from RUN and from IDLE
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("start+stop run busy", int'(bsy[0]), 0);
        chk("start+stop run valid", int'(vld[0]), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("start+stop idle busy", int'(bsy[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
